nios2_mult_pipe_unit: RTL and testbench
=======================================

// Module: nios2_mult_pipe_unit
// PURPOSE
//  Parametrised, pipelined integer multiplier for the CPU M/W stages; successor to the fixed 3-cell 16x16 multiplier.
//  Splits DATA_W operands into halves, registers the partial products, then sums and selects the low or high word.
//  Supports MUL and MULXSS/MULXSU/MULXUU, carries a destination tag, and supports stall (en) and pipeline flush.
// PARAMETERS
//  DATA_W   32  operand/result width; must be even; SLICE_W = DATA_W/2 (localparam)
//  TAG_W    5   width of destination tag carried alongside each op
// PORTS
//  clk         in   1        clock
//  reset_n     in   1        async active-low reset
//  en          in   1        pipeline advance enable; 0 freezes all stage registers
//  flush       in   1        sync kill of all in-flight and incoming ops
//  in_valid    in   1        op present on in_* / src*
//  in_op       in   2        00 MUL, 01 MULXSS, 10 MULXSU, 11 MULXUU
//  in_tag      in   TAG_W    destination tag
//  src1        in   DATA_W   operand A (signed for MULXSS/MULXSU)
//  src2        in   DATA_W   operand B (signed for MULXSS only)
//  out_valid   out  1        result/out_tag valid this cycle
//  out_tag     out  TAG_W    tag of completing op
//  result      out  DATA_W   low word (MUL) or high word (MULX*) of 2*DATA_W product
//  out_illegal out  1        MULX* issued with full product compiled out
//  busy        out  1        stage-1 holds a valid op
// BEHAVIOUR
//  - Reset (async, reset_n=0): s1_valid, out_valid, busy, out_illegal=0; result, out_tag, all partial regs = 0.
//  - Stage 1 (on clk when en=1): capture pp_ll=aL*bL, pp_lh=aL*bH, pp_hl=aH*bL, pp_hh=aH*bH, op, tag, s1_valid=in_valid.
//    Low halves are always unsigned; aH signed iff op in {MULXSS,MULXSU}; bH signed iff op==MULXSS.
//    Cross/high products are (SLICE_W+1)x(SLICE_W+1) signed, 2*SLICE_W+2 bits, sign-extended before the sum.
//  - Stage 2 (on clk when en=1): P = pp_ll + (pp_lh+pp_hl)<<SLICE_W + pp_hh<<DATA_W, modulo 2^(2*DATA_W);
//    result = P[DATA_W-1:0] for MUL, else P[2*DATA_W-1:DATA_W]; out_valid=s1_valid; out_tag=s1 tag.
//  - Latency: exactly 2 en-cycles from in_valid accept to out_valid; throughput 1 op/cycle; in-order.
//  - An op is accepted when in_valid & en & ~flush. No backpressure port; the caller stalls via en.
//  - en=0: all registers hold, including out_valid/result; an outstanding result stays asserted until the next en=1 edge.
//  - out_valid with en=1 is a one-cycle pulse per op; result holds its last value when out_valid=0.
//  - flush=1 on a clk edge: s1_valid, out_valid=0 regardless of en; incoming op dropped; data regs may update or hold (don't care).
//  - flush and in_valid in the same cycle: flush wins.
//  - Reset mid-operation: all in-flight ops lost, no out_valid after release until a new op is accepted.
//  - busy = s1_valid (combinational from register).
//  - MUL ignores signedness (low word is sign-agnostic); MUL with any operands never sets out_illegal.
// CONFIGURATION
//  NIOS2_MULT_FULL_PRODUCT_EN defined: all four partial products built; MULX* return the correct high word; out_illegal tied 0.
//  Undefined: pp_hh and sign handling omitted (3 unsigned cells, low word only, pp_lh/pp_hl truncated to DATA_W-SLICE_W bits);
//    MUL is unchanged; MULX* complete at normal latency with result=0, out_illegal=1 in the out_valid cycle.
// TESTING
//  1 MUL src1=0x0001_0003, src2=0x0002_0005, tag 3 -> 2 cycles later out_valid=1, result=0x000B_000F, out_tag=3.
//  2 MULXUU same operands -> result=0x0000_0002; MULXUU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MULXSS same -> 0x00000000; MULXSU same -> 0xFFFFFFFF.
//  3 Four back-to-back ops (tags 1..4), en=1 -> out_valid high 4 consecutive cycles, tags 1,2,3,4 in order, correct results.
//  4 Accept MUL 7*6, drop en for 3 cycles after stage 1 -> no out_valid during stall; result=42 one cycle after en returns, held if en drops again.
//  5 flush with op in stage 1 and new in_valid same cycle -> neither op produces out_valid; busy=0 the next cycle.
//  6 Pulse reset_n low with ops in both stages -> out_valid, busy, result, out_tag = 0 immediately; nothing completes after release.
//    With the macro undefined: MULXSS any operands -> result=0, out_illegal=1; MUL 0x0001_0003*0x0002_0005 -> 0x000B_000F.

Source files
------------

// File: rtl/nios2_mult_pipe_unit.sv
// nios2_mult_pipe_unit: two-stage pipelined integer multiplier for the CPU M/W stages.
// Stage 1 splits the operands into halves and registers the partial products.
// Stage 2 sums them and returns either the low word (MUL) or the high word (MULX*).
// Build option NIOS2_MULT_FULL_PRODUCT_EN: when defined, all four partial products are
// built with sign handling and MULX* return the true high word. When undefined, only the
// three cells needed for the low word exist, and MULX* complete with result 0 and
// out_illegal set.
module nios2_mult_pipe_unit #(
   parameter int DATA_W = 32,
   parameter int TAG_W  = 5
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              en,
   input  logic              flush,
   input  logic              in_valid,
   input  logic [1:0]        in_op,
   input  logic [TAG_W-1:0]  in_tag,
   input  logic [DATA_W-1:0] src1,
   input  logic [DATA_W-1:0] src2,
   output logic              out_valid,
   output logic [TAG_W-1:0]  out_tag,
   output logic [DATA_W-1:0] result,
   output logic              out_illegal,
   output logic              busy
);

   localparam int SLICE_W = DATA_W / 2;
   localparam int P_W     = 2 * DATA_W;
   localparam logic [1:0] OP_MUL    = 2'b00;
   localparam logic [1:0] OP_MULXSS = 2'b01;
   localparam logic [1:0] OP_MULXSU = 2'b10;

`ifdef NIOS2_MULT_FULL_PRODUCT_EN
   // Cross and high products are (SLICE_W+1)x(SLICE_W+1) signed values.
   localparam int PP_W = 2 * SLICE_W + 2;
`else
   // Only the low word is needed, so the cross products are truncated.
   localparam int PP_W = SLICE_W;
`endif

   // Operand halves.
   logic [SLICE_W-1:0] w_a_lo, w_a_hi, w_b_lo, w_b_hi;
   assign w_a_lo = src1[SLICE_W-1:0];
   assign w_a_hi = src1[DATA_W-1:SLICE_W];
   assign w_b_lo = src2[SLICE_W-1:0];
   assign w_b_hi = src2[DATA_W-1:SLICE_W];

   // The low x low product is always unsigned.
   logic [DATA_W-1:0] w_pp_ll;
   assign w_pp_ll = {{SLICE_W{1'b0}}, w_a_lo} * {{SLICE_W{1'b0}}, w_b_lo};

   logic [PP_W-1:0] w_pp_lh, w_pp_hl;

`ifdef NIOS2_MULT_FULL_PRODUCT_EN
   // The upper halves are sign-extended according to the op. The operands are widened
   // to PP_W, so an unsigned multiply truncated to PP_W gives the exact signed product.
   logic            w_a_sgn, w_b_sgn;
   logic [PP_W-1:0] w_a_lo_x, w_a_hi_x, w_b_lo_x, w_b_hi_x;
   logic [PP_W-1:0] w_pp_hh;
   assign w_a_sgn  = (in_op == OP_MULXSS) || (in_op == OP_MULXSU);
   assign w_b_sgn  = (in_op == OP_MULXSS);
   assign w_a_lo_x = {{(PP_W-SLICE_W){1'b0}}, w_a_lo};
   assign w_b_lo_x = {{(PP_W-SLICE_W){1'b0}}, w_b_lo};
   assign w_a_hi_x = {{(PP_W-SLICE_W){w_a_sgn & w_a_hi[SLICE_W-1]}}, w_a_hi};
   assign w_b_hi_x = {{(PP_W-SLICE_W){w_b_sgn & w_b_hi[SLICE_W-1]}}, w_b_hi};
   assign w_pp_lh  = w_a_lo_x * w_b_hi_x;
   assign w_pp_hl  = w_a_hi_x * w_b_lo_x;
   assign w_pp_hh  = w_a_hi_x * w_b_hi_x;
`else
   assign w_pp_lh = w_a_lo * w_b_hi;
   assign w_pp_hl = w_a_hi * w_b_lo;
`endif

   // Stage-1 registers.
   logic              r_s1_valid;
   logic [1:0]        r_s1_op;
   logic [TAG_W-1:0]  r_s1_tag;
   logic [DATA_W-1:0] r_pp_ll;
   logic [PP_W-1:0]   r_pp_lh, r_pp_hl;
`ifdef NIOS2_MULT_FULL_PRODUCT_EN
   logic [PP_W-1:0]   r_pp_hh;
`endif

   // Stage 1: capture the partial products. Flush kills the op regardless of en.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_s1_valid <= 1'b0;
         r_s1_op    <= OP_MUL;
         r_s1_tag   <= '0;
         r_pp_ll    <= '0;
         r_pp_lh    <= '0;
         r_pp_hl    <= '0;
`ifdef NIOS2_MULT_FULL_PRODUCT_EN
         r_pp_hh    <= '0;
`endif
      end else begin
         if (flush) begin
            r_s1_valid <= 1'b0;
         end else if (en) begin
            r_s1_valid <= in_valid;
         end
         if (en) begin
            r_s1_op  <= in_op;
            r_s1_tag <= in_tag;
            r_pp_ll  <= w_pp_ll;
            r_pp_lh  <= w_pp_lh;
            r_pp_hl  <= w_pp_hl;
`ifdef NIOS2_MULT_FULL_PRODUCT_EN
            r_pp_hh  <= w_pp_hh;
`endif
         end
      end
   end

   // Stage-2 combinational sum and word select.
   logic [DATA_W-1:0] w_result;
   logic              w_illegal;

`ifdef NIOS2_MULT_FULL_PRODUCT_EN
   logic [P_W-1:0] w_p;
   assign w_p = {{(P_W-DATA_W){1'b0}}, r_pp_ll}
              + ({{(P_W-PP_W){r_pp_lh[PP_W-1]}}, r_pp_lh} << SLICE_W)
              + ({{(P_W-PP_W){r_pp_hl[PP_W-1]}}, r_pp_hl} << SLICE_W)
              + ({{(P_W-PP_W){r_pp_hh[PP_W-1]}}, r_pp_hh} << DATA_W);
   assign w_result  = (r_s1_op == OP_MUL) ? w_p[DATA_W-1:0] : w_p[P_W-1:DATA_W];
   assign w_illegal = 1'b0;
`else
   logic [DATA_W-1:0] w_low;
   assign w_low     = r_pp_ll + {r_pp_lh + r_pp_hl, {SLICE_W{1'b0}}};
   assign w_result  = (r_s1_op == OP_MUL) ? w_low : '0;
   assign w_illegal = (r_s1_op != OP_MUL);
`endif

   // Output registers.
   logic              r_out_valid;
   logic              r_out_illegal;
   logic [TAG_W-1:0]  r_out_tag;
   logic [DATA_W-1:0] r_result;

   // Stage 2: register the result. The data registers only update for a real op, so the
   // result holds between completions.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_out_valid   <= 1'b0;
         r_out_illegal <= 1'b0;
         r_out_tag     <= '0;
         r_result      <= '0;
      end else begin
         if (flush) begin
            r_out_valid   <= 1'b0;
            r_out_illegal <= 1'b0;
         end else if (en) begin
            r_out_valid   <= r_s1_valid;
            r_out_illegal <= r_s1_valid & w_illegal;
         end
         if (en && r_s1_valid && !flush) begin
            r_out_tag <= r_s1_tag;
            r_result  <= w_result;
         end
      end
   end

   assign out_valid   = r_out_valid;
   assign out_tag     = r_out_tag;
   assign result      = r_result;
   assign out_illegal = r_out_illegal;
   assign busy        = r_s1_valid;

endmodule

// File: tb/tb_nios2_mult_pipe_unit.sv
// tb_nios2_mult_pipe_unit: directed self-checking bench for nios2_mult_pipe_unit.
// The expected values for MULX* follow NIOS2_MULT_FULL_PRODUCT_EN when it is defined.
module tb_nios2_mult_pipe_unit;

   localparam int DATA_W = 32;
   localparam int TAG_W  = 5;

   logic              clk = 1'b0;
   logic              reset_n;
   logic              en;
   logic              flush;
   logic              in_valid;
   logic [1:0]        in_op;
   logic [TAG_W-1:0]  in_tag;
   logic [DATA_W-1:0] src1;
   logic [DATA_W-1:0] src2;
   logic              out_valid;
   logic [TAG_W-1:0]  out_tag;
   logic [DATA_W-1:0] result;
   logic              out_illegal;
   logic              busy;

   int n_cmp = 0;
   int n_bad = 0;

`ifdef NIOS2_MULT_FULL_PRODUCT_EN
   localparam logic [31:0] EXP_XUU_SMALL = 32'h0000_0002;
   localparam logic [31:0] EXP_XUU_ONES  = 32'hFFFF_FFFE;
   localparam logic [31:0] EXP_XSS_ONES  = 32'h0000_0000;
   localparam logic [31:0] EXP_XSU_ONES  = 32'hFFFF_FFFF;
   localparam logic        EXP_ILL       = 1'b0;
`else
   localparam logic [31:0] EXP_XUU_SMALL = 32'h0;
   localparam logic [31:0] EXP_XUU_ONES  = 32'h0;
   localparam logic [31:0] EXP_XSS_ONES  = 32'h0;
   localparam logic [31:0] EXP_XSU_ONES  = 32'h0;
   localparam logic        EXP_ILL       = 1'b1;
`endif

   nios2_mult_pipe_unit #(.DATA_W(DATA_W), .TAG_W(TAG_W)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .en          (en),
      .flush       (flush),
      .in_valid    (in_valid),
      .in_op       (in_op),
      .in_tag      (in_tag),
      .src1        (src1),
      .src2        (src2),
      .out_valid   (out_valid),
      .out_tag     (out_tag),
      .result      (result),
      .out_illegal (out_illegal),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   // Each comparison is counted here, and a mismatch is reported here.
   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [1:0] op, input logic [TAG_W-1:0] tag,
                        input logic [31:0] a, input logic [31:0] b);
      in_valid = 1'b1;
      in_op    = op;
      in_tag   = tag;
      src1     = a;
      src2     = b;
   endtask

   // Issue one op, check its completion two cycles later, and check that out_valid is a one-cycle pulse.
   task automatic run_op(input string name, input logic [1:0] op, input logic [TAG_W-1:0] tag,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_res, input logic exp_ill);
      drive(op, tag, a, b);
      step();
      in_valid = 1'b0;
      check_val({name, ".no_early_valid"}, 64'(out_valid), 64'd0);
      step();
      $display("op %s op=%0d tag=%0d a=0x%08h b=0x%08h -> valid=%0b tag=%0d result=0x%08h illegal=%0b",
               name, op, tag, a, b, out_valid, out_tag, result, out_illegal);
      check_val({name, ".valid"},   64'(out_valid),   64'd1);
      check_val({name, ".tag"},     64'(out_tag),     64'(tag));
      check_val({name, ".result"},  64'(result),      64'(exp_res));
      check_val({name, ".illegal"}, 64'(out_illegal), 64'(exp_ill));
      step();
      check_val({name, ".pulse"},   64'(out_valid),   64'd0);
   endtask

   logic [1:0]        bb_op  [4];
   logic [31:0]       bb_a   [4];
   logic [31:0]       bb_b   [4];
   logic [31:0]       bb_exp [4];

   initial begin
      reset_n  = 1'b0;
      en       = 1'b1;
      flush    = 1'b0;
      in_valid = 1'b0;
      in_op    = 2'b00;
      in_tag   = '0;
      src1     = '0;
      src2     = '0;
      step();
      check_val("rst.out_valid",   64'(out_valid),   64'd0);
      check_val("rst.busy",        64'(busy),        64'd0);
      check_val("rst.result",      64'(result),      64'd0);
      check_val("rst.out_tag",     64'(out_tag),     64'd0);
      check_val("rst.out_illegal", 64'(out_illegal), 64'd0);
      step();
      reset_n = 1'b1;
      step();

      // Basic MUL, and the MULX* variants.
      run_op("mul_small",  2'b00, 5'd3,  32'h0001_0003, 32'h0002_0005, 32'h000B_000F, 1'b0);
      run_op("xuu_small",  2'b11, 5'd4,  32'h0001_0003, 32'h0002_0005, EXP_XUU_SMALL, EXP_ILL);
      run_op("xuu_ones",   2'b11, 5'd5,  32'hFFFF_FFFF, 32'hFFFF_FFFF, EXP_XUU_ONES,  EXP_ILL);
      run_op("xss_ones",   2'b01, 5'd6,  32'hFFFF_FFFF, 32'hFFFF_FFFF, EXP_XSS_ONES,  EXP_ILL);
      run_op("xsu_ones",   2'b10, 5'd7,  32'hFFFF_FFFF, 32'hFFFF_FFFF, EXP_XSU_ONES,  EXP_ILL);
      run_op("mul_ones",   2'b00, 5'd8,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
`ifndef NIOS2_MULT_FULL_PRODUCT_EN
      run_op("xss_any",    2'b01, 5'd9,  32'h1234_5678, 32'h9ABC_DEF0, 32'h0,         1'b1);
`endif
      run_op("mul_small2", 2'b00, 5'd10, 32'h0001_0003, 32'h0002_0005, 32'h000B_000F, 1'b0);

      // Four back-to-back ops, which must complete on consecutive cycles in order.
      bb_op[0] = 2'b00; bb_a[0] = 32'd7;          bb_b[0] = 32'd6;          bb_exp[0] = 32'd42;
      bb_op[1] = 2'b00; bb_a[1] = 32'hFFFF_FFFF;  bb_b[1] = 32'hFFFF_FFFF;  bb_exp[1] = 32'h1;
      bb_op[2] = 2'b00; bb_a[2] = 32'h1234_5678;  bb_b[2] = 32'h10;         bb_exp[2] = 32'h2345_6780;
      bb_op[3] = 2'b00; bb_a[3] = 32'h8000_0000;  bb_b[3] = 32'h2;          bb_exp[3] = 32'h0;
      for (int i = 0; i < 6; i++) begin
         if (i < 4) drive(bb_op[i], TAG_W'(i + 1), bb_a[i], bb_b[i]);
         else in_valid = 1'b0;
         step();
         if (i >= 1 && i <= 4) begin
            $display("b2b cycle %0d: valid=%0b tag=%0d result=0x%08h", i, out_valid, out_tag, result);
            check_val("b2b.valid",  64'(out_valid), 64'd1);
            check_val("b2b.tag",    64'(out_tag),   64'(i));
            check_val("b2b.result", 64'(result),    64'(bb_exp[i-1]));
         end else if (i == 5) begin
            check_val("b2b.end_valid", 64'(out_valid), 64'd0);
         end
      end

      // Stall with the op in stage 1. Nothing may complete while en is low.
      drive(2'b00, 5'd11, 32'd7, 32'd6);
      step();
      in_valid = 1'b0;
      en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         check_val("stall.no_valid", 64'(out_valid), 64'd0);
         check_val("stall.busy",     64'(busy),      64'd1);
      end
      en = 1'b1;
      step();
      $display("stall release: valid=%0b tag=%0d result=%0d", out_valid, out_tag, result);
      check_val("stall.valid",  64'(out_valid), 64'd1);
      check_val("stall.result", 64'(result),    64'd42);
      check_val("stall.tag",    64'(out_tag),   64'd11);
      en = 1'b0;
      for (int i = 0; i < 2; i++) begin
         step();
         check_val("stall.hold_valid",  64'(out_valid), 64'd1);
         check_val("stall.hold_result", 64'(result),    64'd42);
      end
      en = 1'b1;
      step();
      check_val("stall.drop_valid",  64'(out_valid), 64'd0);
      check_val("stall.keep_result", 64'(result),    64'd42);

      // A flush arrives while an op is in stage 1 and a new op is offered. Both ops are dropped.
      drive(2'b00, 5'd12, 32'd3, 32'd5);
      step();
      drive(2'b00, 5'd13, 32'd9, 32'd9);
      flush = 1'b1;
      step();
      flush    = 1'b0;
      in_valid = 1'b0;
      check_val("flush.valid", 64'(out_valid), 64'd0);
      check_val("flush.busy",  64'(busy),      64'd0);
      for (int i = 0; i < 2; i++) begin
         step();
         check_val("flush.after_valid", 64'(out_valid), 64'd0);
         check_val("flush.after_busy",  64'(busy),      64'd0);
      end
      check_val("flush.result_held", 64'(result), 64'd42);

      // Reset pulse while ops sit in both stages.
      drive(2'b00, 5'd14, 32'd100, 32'd3);
      step();
      drive(2'b00, 5'd15, 32'd11, 32'd11);
      step();
      in_valid = 1'b0;
      check_val("rst2.pre_valid",  64'(out_valid), 64'd1);
      check_val("rst2.pre_result", 64'(result),    64'd300);
      check_val("rst2.pre_busy",   64'(busy),      64'd1);
      #1 reset_n = 1'b0;
      #1;
      $display("reset pulse: valid=%0b busy=%0b tag=%0d result=0x%08h", out_valid, busy, out_tag, result);
      check_val("rst2.valid",  64'(out_valid), 64'd0);
      check_val("rst2.busy",   64'(busy),      64'd0);
      check_val("rst2.result", 64'(result),    64'd0);
      check_val("rst2.tag",    64'(out_tag),   64'd0);
      #2 reset_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check_val("rst2.after_valid", 64'(out_valid), 64'd0);
         check_val("rst2.after_busy",  64'(busy),      64'd0);
      end

      // The unit must still work after the reset pulse.
      run_op("mul_post_rst", 2'b00, 5'd16, 32'h0001_0003, 32'h0002_0005, 32'h000B_000F, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
